ext_irq_gateway: RTL and testbench

- Sits directly upstream of the core top and drives its external_interrupt input.
- Collects SRC_NUM asynchronous peripheral interrupt lines and synchronises each one.
- Latches each source as level- or edge-triggered, applies an enable mask and a fixed-priority claim/complete protocol.
- Software accesses it through a valid/ready register port of the same shape as the core's interrupt-agent port.

---
 rtl/ext_irq_gateway_if.sv | 24 ++
 rtl/ext_irq_gateway.sv | 137 +++++++++++++
 tb/tb_ext_irq_gateway.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_irq_gateway_if.sv
// Register-port bundle between software (master) and the interrupt gateway (slave).
// Valid/ready handshake: one request cycle, one ready pulse carrying read data.
interface ext_irq_gateway_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
);
  logic              gw_i_valid;
  logic              gw_i_wr;
  logic              gw_i_rd;
  logic [ADDR_W-1:0] gw_i_addr;
  logic [XLEN-1:0]   gw_i_wdata;
  logic [XLEN-1:0]   gw_o_rdata;
  logic              gw_o_ready;

  modport master (
    output gw_i_valid, gw_i_wr, gw_i_rd, gw_i_addr, gw_i_wdata,
    input  gw_o_rdata, gw_o_ready
  );

  modport slave (
    input  gw_i_valid, gw_i_wr, gw_i_rd, gw_i_addr, gw_i_wdata,
    output gw_o_rdata, gw_o_ready
  );
endinterface

// File: rtl/ext_irq_gateway.sv
// External interrupt gateway: synchronises SRC_NUM raw lines, latches them as level or edge,
// masks them and arbitrates a fixed-priority claim/complete protocol over a register port.
module ext_irq_gateway #(
  parameter int SRC_NUM = 8,
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SRC_NUM-1:0] gw_i_irq_src,
  ext_irq_gateway_if.slave   bus,
  output logic               gw_o_external_interrupt
);

  localparam int ID_W = $clog2(SRC_NUM + 1);

  localparam logic [ADDR_W-3:0] W_PENDING   = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] W_ENABLE    = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] W_EDGE_SEL  = (ADDR_W-2)'(2);
  localparam logic [ADDR_W-3:0] W_INSERVICE = (ADDR_W-2)'(3);
  localparam logic [ADDR_W-3:0] W_CLAIM     = (ADDR_W-2)'(4);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state_reg, state_next;

  logic [SRC_NUM-1:0] s1_reg, s2_reg, s3_reg;
  logic [SRC_NUM-1:0] pending_reg, pending_next;
  logic [SRC_NUM-1:0] enable_reg, enable_next;
  logic [SRC_NUM-1:0] edge_sel_reg, edge_sel_next;
  logic [SRC_NUM-1:0] inservice_reg, inservice_next;
  logic [SRC_NUM-1:0] claimable, set_mask, claim_mask, complete_mask;
  logic [XLEN-1:0]    rdata_reg, rdata_next, rd_value;
  logic               irq_reg;
  logic [ID_W-1:0]    claim_id;
  logic [ADDR_W-3:0]  word_addr;
  logic               access, do_wr, do_rd, sel_claim;
  logic [1:0]         unused_addr_bits;

  assign word_addr        = bus.gw_i_addr[ADDR_W-1:2];
  assign unused_addr_bits = bus.gw_i_addr[1:0];
  assign access           = (state_reg == IDLE) && bus.gw_i_valid;
  // A request with both strobes set is a write.
  assign do_wr            = access && bus.gw_i_wr;
  assign do_rd            = access && bus.gw_i_rd && !bus.gw_i_wr;
  assign sel_claim        = (word_addr == W_CLAIM);
  assign claimable        = pending_reg & enable_reg & ~inservice_reg;

  // Lowest index wins, so scan from the top down.
  always_comb begin
    claim_id = '0;
    for (int i = SRC_NUM - 1; i >= 0; i--) begin
      if (claimable[i]) claim_id = ID_W'(i + 1);
    end
  end

  generate
    for (genvar gi = 0; gi < SRC_NUM; gi++) begin : g_src
      assign set_mask[gi] = edge_sel_reg[gi]
                          ? (s2_reg[gi] & ~s3_reg[gi])
                          : (s2_reg[gi] & ~inservice_reg[gi] & ~pending_reg[gi]);
      assign claim_mask[gi]    = do_rd && sel_claim && (claim_id == ID_W'(gi + 1));
      assign complete_mask[gi] = do_wr && sel_claim && inservice_reg[gi]
                               && (bus.gw_i_wdata == XLEN'(gi + 1));
    end
  endgenerate

  // New set is ORed after the claim clear so a coincident edge is never lost.
  always_comb begin
    pending_next   = (pending_reg & ~claim_mask) | set_mask;
    inservice_next = (inservice_reg & ~complete_mask) | claim_mask;
    enable_next    = enable_reg;
    edge_sel_next  = edge_sel_reg;
    if (do_wr && word_addr == W_ENABLE)   enable_next   = bus.gw_i_wdata[SRC_NUM-1:0];
    if (do_wr && word_addr == W_EDGE_SEL) edge_sel_next = bus.gw_i_wdata[SRC_NUM-1:0];
  end

  always_comb begin
    rd_value = '0;
    case (word_addr)
      W_PENDING:   rd_value = XLEN'(pending_reg);
      W_ENABLE:    rd_value = XLEN'(enable_reg);
      W_EDGE_SEL:  rd_value = XLEN'(edge_sel_reg);
      W_INSERVICE: rd_value = XLEN'(inservice_reg);
      W_CLAIM:     rd_value = XLEN'(claim_id);
      default:     rd_value = '0;
    endcase
    rdata_next = do_rd ? rd_value : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg        <= '0;
      s2_reg        <= '0;
      s3_reg        <= '0;
      pending_reg   <= '0;
      enable_reg    <= '0;
      edge_sel_reg  <= '0;
      inservice_reg <= '0;
      rdata_reg     <= '0;
      irq_reg       <= 1'b0;
    end else begin
      s1_reg        <= gw_i_irq_src;
      s2_reg        <= s1_reg;
      s3_reg        <= s2_reg;
      pending_reg   <= pending_next;
      enable_reg    <= enable_next;
      edge_sel_reg  <= edge_sel_next;
      inservice_reg <= inservice_next;
      rdata_reg     <= rdata_next;
      irq_reg       <= |claimable;
    end
  end

  assign gw_o_external_interrupt = irq_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.gw_i_valid) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset landing in the response cycle suppresses the ready pulse.
  always_comb begin
    bus.gw_o_ready = (state_reg == RESP) && !rst;
    bus.gw_o_rdata = bus.gw_o_ready ? rdata_reg : '0;
  end

endmodule

// File: tb/tb_ext_irq_gateway.sv
// Directed plus randomized bench for ext_irq_gateway with a transaction-level reference model.
module tb_ext_irq_gateway;
  localparam int SRC_NUM = 8;
  localparam int XLEN    = 32;
  localparam int ADDR_W  = 12;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [SRC_NUM-1:0] src = '0;
  logic               irq;
  int                 n_checks = 0;
  int                 n_pass   = 0;
  int                 n_fail   = 0;

  ext_irq_gateway_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  ext_irq_gateway #(.SRC_NUM(SRC_NUM), .XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .gw_i_irq_src            (src),
    .bus                     (bus),
    .gw_o_external_interrupt (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_pend = '0, m_en = '0, m_edge = '0, m_ins = '0;
  logic [7:0]  hist[$] = '{8'h00, 8'h00, 8'h00};
  bit          m_busy = 0, m_irq = 0;
  logic [31:0] m_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_id(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [7:0] s2, s3, np, ni, ne, ned;
    logic [31:0] nr;
    bit nb;
    int word, k, id;
    if (rst) begin
      m_pend = '0; m_en = '0; m_edge = '0; m_ins = '0;
      m_busy = 0; m_irq = 0; m_rdata = '0;
      hist = '{8'h00, 8'h00, 8'h00};
    end else begin
      s2 = hist[1];
      s3 = hist[2];
      np = m_pend; ni = m_ins; ne = m_en; ned = m_edge;
      nb = 0; nr = '0;
      if (!m_busy && bus.gw_i_valid) begin
        nb   = 1;
        word = int'(bus.gw_i_addr >> 2);
        if (bus.gw_i_wr) begin
          if (word == 1) ne = bus.gw_i_wdata[7:0];
          else if (word == 2) ned = bus.gw_i_wdata[7:0];
          else if (word == 4 && bus.gw_i_wdata >= 1 && bus.gw_i_wdata <= 8) begin
            k = int'(bus.gw_i_wdata);
            if (m_ins[k-1]) ni[k-1] = 1'b0;
          end
        end else if (bus.gw_i_rd) begin
          case (word)
            0: nr = {24'h0, m_pend};
            1: nr = {24'h0, m_en};
            2: nr = {24'h0, m_edge};
            3: nr = {24'h0, m_ins};
            4: begin
              id = lowest_id(m_pend & m_en & ~m_ins);
              nr = id;
              if (id != 0) begin
                np[id-1] = 1'b0;
                ni[id-1] = 1'b1;
              end
            end
            default: nr = '0;
          endcase
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (m_edge[i]) begin
          if (s2[i] && !s3[i]) np[i] = 1'b1;
        end else if (s2[i] && !m_ins[i] && !m_pend[i]) begin
          np[i] = 1'b1;
        end
      end
      m_irq   = |(m_pend & m_en & ~m_ins);
      m_pend  = np; m_ins = ni; m_en = ne; m_edge = ned;
      m_busy  = nb; m_rdata = nr;
      hist.push_front(src);
      void'(hist.pop_back());
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("ready", {31'h0, bus.gw_o_ready}, {31'h0, m_busy});
    chk("rdata", bus.gw_o_rdata, m_busy ? m_rdata : 32'h0);
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic access(input bit wr, input bit rd, input logic [11:0] a,
                        input logic [31:0] wd, output logic [31:0] rdv);
    bus.gw_i_valid = 1'b1; bus.gw_i_wr = wr; bus.gw_i_rd = rd;
    bus.gw_i_addr  = a;    bus.gw_i_wdata = wd;
    cycle();
    rdv = bus.gw_o_rdata;
    bus.gw_i_valid = 1'b0; bus.gw_i_wr = 1'b0; bus.gw_i_rd = 1'b0;
    cycle();
    $display("access wr=%0b rd=%0b addr=%03h wdata=%0h rdata=%0h", wr, rd, a, wd, rdv);
  endtask

  task automatic rd_reg(input logic [11:0] a, output logic [31:0] rdv);
    access(1'b0, 1'b1, a, 32'h0, rdv);
  endtask

  task automatic wr_reg(input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    access(1'b1, 1'b0, a, wd, dummy);
  endtask

  task automatic pulse(input logic [7:0] v);
    src = v;
    cycles(3);
    src = '0;
    cycles(4);
  endtask

  initial begin
    logic [31:0] r;
    bus.gw_i_valid = 1'b0; bus.gw_i_wr = 1'b0; bus.gw_i_rd = 1'b0;
    bus.gw_i_addr  = '0;   bus.gw_i_wdata = '0;

    // Reset with all lines high
    rst = 1'b1; src = 8'hFF;
    cycles(2);
    chk("rst_ready", {31'h0, bus.gw_o_ready}, 32'h0);
    chk("rst_rdata", bus.gw_o_rdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    rd_reg(12'h000, r);  chk("pend_after_rst", r, 32'h00);
    cycles(2);
    rd_reg(12'h000, r);  chk("pend_all_level", r, 32'hFF);
    chk("irq_masked", {31'h0, irq}, 32'h0);

    // Level source 3
    rst = 1'b1; src = '0;
    cycle();
    rst = 1'b0;
    wr_reg(12'h004, 32'h08);
    src = 8'h08;
    cycles(3);
    chk("lvl_irq_n3", {31'h0, irq}, 32'h0);
    cycle();
    chk("lvl_irq_n4", {31'h0, irq}, 32'h1);
    rd_reg(12'h010, r);  chk("lvl_claim", r, 32'd4);
    rd_reg(12'h00C, r);  chk("lvl_inservice", r, 32'h08);
    chk("lvl_irq_drop", {31'h0, irq}, 32'h0);
    wr_reg(12'h010, 32'd4);
    chk("lvl_repend_wait", {31'h0, irq}, 32'h0);
    cycle();
    chk("lvl_repend_irq", {31'h0, irq}, 32'h1);
    src = '0;
    rd_reg(12'h010, r);  chk("lvl_claim2", r, 32'd4);
    wr_reg(12'h010, 32'd4);

    // Edge priority
    wr_reg(12'h008, 32'hFF);
    wr_reg(12'h004, 32'hFF);
    pulse(8'h22);
    rd_reg(12'h010, r);  chk("prio_claim_a", r, 32'd2);
    rd_reg(12'h010, r);  chk("prio_claim_b", r, 32'd6);
    rd_reg(12'h010, r);  chk("prio_claim_c", r, 32'd0);
    rd_reg(12'h000, r);  chk("prio_pend", r, 32'h00);
    wr_reg(12'h010, 32'd2);
    wr_reg(12'h010, 32'd6);
    rd_reg(12'h00C, r);  chk("prio_ins_clear", r, 32'h00);

    // Edge arriving while in service
    pulse(8'h01);
    rd_reg(12'h010, r);  chk("svc_claim", r, 32'd1);
    pulse(8'h01);
    rd_reg(12'h000, r);  chk("svc_pend", r, 32'h01);
    chk("svc_irq_held", {31'h0, irq}, 32'h0);
    wr_reg(12'h010, 32'd1);
    chk("svc_irq_after", {31'h0, irq}, 32'h1);
    rd_reg(12'h010, r);  chk("svc_claim2", r, 32'd1);
    wr_reg(12'h010, 32'd1);

    // Bogus completes and unmapped access
    pulse(8'h02);
    rd_reg(12'h010, r);  chk("bogus_claim", r, 32'd2);
    wr_reg(12'h010, 32'd0);
    wr_reg(12'h010, 32'd9);
    wr_reg(12'h010, 32'd3);
    rd_reg(12'h00C, r);  chk("bogus_ins", r, 32'h02);
    bus.gw_i_valid = 1'b1; bus.gw_i_rd = 1'b1; bus.gw_i_addr = 12'h020;
    cycle();
    chk("unmap_ready", {31'h0, bus.gw_o_ready}, 32'h1);
    chk("unmap_rdata", bus.gw_o_rdata, 32'h0);
    bus.gw_i_valid = 1'b0; bus.gw_i_rd = 1'b0;
    cycle();
    chk("unmap_ready_drop", {31'h0, bus.gw_o_ready}, 32'h0);
    wr_reg(12'h010, 32'd2);

    // Randomized traffic against the model
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 2) == 0) src = src ^ 8'(1 << $urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       wr_reg(12'h004, $urandom);
        1:       wr_reg(12'h008, $urandom);
        2, 3:    rd_reg(12'h010, r);
        4:       wr_reg(12'h010, 32'($urandom_range(0, 9)));
        5:       rd_reg(12'($urandom_range(0, 5) * 4 + $urandom_range(0, 3)), r);
        6:       cycle();
        default: access(1'b1, 1'b1, 12'(12'h004 + $urandom_range(0, 3)), $urandom, r);
      endcase
    end

    // Reset landing in the response cycle
    rst = 1'b1; src = '0;
    cycle();
    rst = 1'b0;
    wr_reg(12'h008, 32'h04);
    pulse(8'h04);
    bus.gw_i_valid = 1'b1; bus.gw_i_rd = 1'b1; bus.gw_i_addr = 12'h010;
    cycle();
    rst = 1'b1;
    #1;
    chk("abort_ready", {31'h0, bus.gw_o_ready}, 32'h0);
    chk("abort_rdata", bus.gw_o_rdata, 32'h0);
    bus.gw_i_valid = 1'b0; bus.gw_i_rd = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    rd_reg(12'h000, r);  chk("abort_pend", r, 32'h00);
    rd_reg(12'h00C, r);  chk("abort_ins", r, 32'h00);
    chk("abort_irq", {31'h0, irq}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
